// File: rtl/tinyqv_pkg.sv
// tinyqv_pkg: shared definitions for the tinyQV instruction decoder.
// Holds the RV32 major opcodes (instr[6:2]), the tinyqv_alu op encodings,
// the instr_len codes and the decoded-field bundle that is passed between
// the compressed expander and the top-level decoder.
package tinyqv_pkg;

  // Major opcodes, instr[6:2]
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  // tinyqv_alu op encodings: {sub/arith, funct3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // Bits [2:1] of the instruction byte length
  localparam logic [1:0] LEN_32 = 2'b10;
  localparam logic [1:0] LEN_16 = 2'b01;

  // Memory width code used by all compressed loads/stores (word)
  localparam logic [2:0] MEM_WORD = 3'b010;

  typedef logic [3:0] reg_idx_t;

  typedef struct packed {
    logic [31:0] imm;
    logic        is_load;
    logic        is_alu_imm;
    logic        is_auipc;
    logic        is_store;
    logic        is_alu_reg;
    logic        is_lui;
    logic        is_branch;
    logic        is_jalr;
    logic        is_jal;
    logic        is_system;
    logic [3:0]  alu_op;
    logic [2:0]  mem_op;
    reg_idx_t    rs1;
    reg_idx_t    rs2;
    reg_idx_t    rd;
  } decode_t;

  // All-zero decode: no class flag set, so the consumer ignores the rest.
  function automatic decode_t decode_none();
    decode_t d;
    d = {$bits(decode_t){1'b0}};
    return d;
  endfunction

  // Branches compare through the ALU: equality via XOR, ordering via SLT/SLTU.
  function automatic logic [3:0] branch_alu_op(input logic [2:0] funct3);
    logic [3:0] op;
    case (funct3[2:1])
      2'b00:   op = ALU_XOR;
      2'b10:   op = ALU_SLT;
      2'b11:   op = ALU_SLTU;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/tinyqv_instr_decoder_if.sv
// tinyqv_instr_decoder_if: bundle between the fetch buffer, the decoder and
// the execute stage.
//   master : decoder side  (consumes instr, drives decoded fields)
//   slave  : fetch/execute side (drives instr, consumes decoded fields)
interface tinyqv_instr_decoder_if;
  import tinyqv_pkg::*;

  logic [31:0] instr;
  logic [31:0] imm;
  logic        is_load;
  logic        is_alu_imm;
  logic        is_auipc;
  logic        is_store;
  logic        is_alu_reg;
  logic        is_lui;
  logic        is_branch;
  logic        is_jalr;
  logic        is_jal;
  logic        is_system;
  logic        is_ret;
  logic [1:0]  instr_len;
  logic [3:0]  alu_op;
  logic [2:0]  mem_op;
  reg_idx_t    rs1;
  reg_idx_t    rs2;
  reg_idx_t    rd;
  logic [2:0]  additional_mem_ops;
  logic        mem_op_increment_reg;

  modport master (
    input  instr,
    output imm, is_load, is_alu_imm, is_auipc, is_store, is_alu_reg, is_lui,
           is_branch, is_jalr, is_jal, is_system, is_ret, instr_len, alu_op,
           mem_op, rs1, rs2, rd, additional_mem_ops, mem_op_increment_reg
  );

  modport slave (
    output instr,
    input  imm, is_load, is_alu_imm, is_auipc, is_store, is_alu_reg, is_lui,
           is_branch, is_jalr, is_jal, is_system, is_ret, instr_len, alu_op,
           mem_op, rs1, rs2, rd, additional_mem_ops, mem_op_increment_reg
  );
endinterface

// File: rtl/tinyqv_rvc_expand.sv
// tinyqv_rvc_expand: expands a 16-bit RVC instruction into the same decoded
// fields an equivalent RV32 instruction would produce.
//   cinstr : compressed instruction (quadrant 3 is never presented here)
//   dec    : decoded fields; all class flags 0 for unsupported encodings
// Register fields keep only 4 bits (RV32E); 3-bit fields map to x8..x15.
module tinyqv_rvc_expand
  import tinyqv_pkg::*;
(
  input  logic [15:0] cinstr,
  output decode_t     dec
);

  logic [2:0]  f3_s;
  reg_idx_t    r_full_s;   // c[11:7] field, bit 11 dropped
  reg_idx_t    r2_full_s;  // c[6:2] field, bit 6 dropped
  reg_idx_t    rp_hi_s;    // c[9:7]  -> x8..x15
  reg_idx_t    rp_lo_s;    // c[4:2]  -> x8..x15
  logic [31:0] imm6_s;
  logic [31:0] jimm_s;
  logic [31:0] bimm_s;
  logic [31:0] lwimm_s;

  assign f3_s      = cinstr[15:13];
  assign r_full_s  = cinstr[10:7];
  assign r2_full_s = cinstr[5:2];
  assign rp_hi_s   = {1'b1, cinstr[9:7]};
  assign rp_lo_s   = {1'b1, cinstr[4:2]};
  assign imm6_s    = {{26{cinstr[12]}}, cinstr[12], cinstr[6:2]};
  assign jimm_s    = {{20{cinstr[12]}}, cinstr[12], cinstr[8], cinstr[10:9], cinstr[6],
                      cinstr[7], cinstr[2], cinstr[11], cinstr[5:3], 1'b0};
  assign bimm_s    = {{23{cinstr[12]}}, cinstr[12], cinstr[6:5], cinstr[2],
                      cinstr[11:10], cinstr[4:3], 1'b0};
  assign lwimm_s   = {25'd0, cinstr[5], cinstr[12:10], cinstr[6], 2'b00};

  // Quadrant/funct3 expansion to RV32 fields
  always_comb begin
    dec = decode_none();
    case (cinstr[1:0])
      2'b00: begin
        case (f3_s)
          3'b000: begin  // C.ADDI4SPN, zero immediate is illegal
            if (cinstr[12:5] != 8'd0) begin
              dec.is_alu_imm = 1'b1;
              dec.rs1 = 4'd2;
              dec.rd  = rp_lo_s;
              dec.imm = {22'd0, cinstr[10:7], cinstr[12:11], cinstr[5], cinstr[6], 2'b00};
            end else begin
              dec = decode_none();
            end
          end
          3'b010: begin  // C.LW
            dec.is_load = 1'b1;
            dec.rs1 = rp_hi_s;
            dec.rd  = rp_lo_s;
            dec.imm = lwimm_s;
            dec.mem_op = MEM_WORD;
          end
          3'b110: begin  // C.SW
            dec.is_store = 1'b1;
            dec.rs1 = rp_hi_s;
            dec.rs2 = rp_lo_s;
            dec.imm = lwimm_s;
            dec.mem_op = MEM_WORD;
          end
          default: dec = decode_none();
        endcase
      end
      2'b01: begin
        case (f3_s)
          3'b000: begin  // C.ADDI / C.NOP
            dec.is_alu_imm = 1'b1;
            dec.rs1 = r_full_s;
            dec.rd  = r_full_s;
            dec.imm = imm6_s;
          end
          3'b001, 3'b101: begin  // C.JAL links to x1, C.J discards the link
            dec.is_jal = 1'b1;
            dec.rd  = (f3_s == 3'b001) ? 4'd1 : 4'd0;
            dec.imm = jimm_s;
          end
          3'b010: begin  // C.LI
            dec.is_alu_imm = 1'b1;
            dec.rs1 = 4'd0;
            dec.rd  = r_full_s;
            dec.imm = imm6_s;
          end
          3'b011: begin
            if (cinstr[12] == 1'b0 && cinstr[6:2] == 5'd0) begin
              dec = decode_none();
            end else if (cinstr[11:7] == 5'd2) begin  // C.ADDI16SP
              dec.is_alu_imm = 1'b1;
              dec.rs1 = 4'd2;
              dec.rd  = 4'd2;
              dec.imm = {{22{cinstr[12]}}, cinstr[12], cinstr[4:3], cinstr[5], cinstr[2],
                         cinstr[6], 4'd0};
            end else begin  // C.LUI
              dec.is_lui = 1'b1;
              dec.rs1 = 4'd0;
              dec.rd  = r_full_s;
              dec.imm = {{14{cinstr[12]}}, cinstr[12], cinstr[6:2], 12'd0};
            end
          end
          3'b100: begin
            dec.rs1 = rp_hi_s;
            dec.rd  = rp_hi_s;
            case (cinstr[11:10])
              2'b00, 2'b01: begin  // C.SRLI / C.SRAI; shamt[5] illegal on RV32
                if (cinstr[12] == 1'b0) begin
                  dec.is_alu_imm = 1'b1;
                  dec.alu_op = cinstr[10] ? ALU_SRA : ALU_SRL;
                  dec.imm = {21'd0, cinstr[10], 5'd0, cinstr[6:2]};
                end else begin
                  dec = decode_none();
                end
              end
              2'b10: begin  // C.ANDI
                dec.is_alu_imm = 1'b1;
                dec.alu_op = ALU_AND;
                dec.imm = imm6_s;
              end
              default: begin  // register-register group
                if (cinstr[12] == 1'b0) begin
                  dec.is_alu_reg = 1'b1;
                  dec.rs2 = rp_lo_s;
                  case (cinstr[6:5])
                    2'b00:   dec.alu_op = ALU_SUB;
                    2'b01:   dec.alu_op = ALU_XOR;
                    2'b10:   dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                  endcase
                end else begin
                  dec = decode_none();
                end
              end
            endcase
          end
          3'b110, 3'b111: begin  // C.BEQZ / C.BNEZ; mem_op carries the funct3
            dec.is_branch = 1'b1;
            dec.rs1 = rp_hi_s;
            dec.rs2 = 4'd0;
            dec.imm = bimm_s;
            dec.alu_op = ALU_XOR;
            dec.mem_op = {2'b00, f3_s[0]};
          end
          default: dec = decode_none();
        endcase
      end
      2'b10: begin
        case (f3_s)
          3'b000: begin  // C.SLLI
            if (cinstr[12] == 1'b0) begin
              dec.is_alu_imm = 1'b1;
              dec.rs1 = r_full_s;
              dec.rd  = r_full_s;
              dec.alu_op = ALU_SLL;
              dec.imm = {27'd0, cinstr[6:2]};
            end else begin
              dec = decode_none();
            end
          end
          3'b010: begin  // C.LWSP, rd=x0 reserved
            if (cinstr[11:7] != 5'd0) begin
              dec.is_load = 1'b1;
              dec.rs1 = 4'd2;
              dec.rd  = r_full_s;
              dec.mem_op = MEM_WORD;
              dec.imm = {24'd0, cinstr[3:2], cinstr[12], cinstr[6:4], 2'b00};
            end else begin
              dec = decode_none();
            end
          end
          3'b100: begin
            if (cinstr[6:2] != 5'd0) begin  // C.MV (rs1=x0) or C.ADD (rs1=rd)
              dec.is_alu_reg = 1'b1;
              dec.rs1 = cinstr[12] ? r_full_s : 4'd0;
              dec.rs2 = r2_full_s;
              dec.rd  = r_full_s;
            end else if (cinstr[11:7] != 5'd0) begin  // C.JR / C.JALR
              dec.is_jalr = 1'b1;
              dec.rs1 = r_full_s;
              dec.rd  = cinstr[12] ? 4'd1 : 4'd0;
            end else if (cinstr[12] == 1'b1) begin  // C.EBREAK
              dec.is_system = 1'b1;
              dec.imm = 32'd1;
            end else begin
              dec = decode_none();
            end
          end
          3'b110: begin  // C.SWSP
            dec.is_store = 1'b1;
            dec.rs1 = 4'd2;
            dec.rs2 = r2_full_s;
            dec.mem_op = MEM_WORD;
            dec.imm = {24'd0, cinstr[8:7], cinstr[12:9], 2'b00};
          end
          default: dec = decode_none();
        endcase
      end
      default: dec = decode_none();
    endcase
  end

endmodule

// File: rtl/tinyqv_instr_decoder.sv
// tinyqv_instr_decoder: combinational RV32EC instruction decoder.
//   clk, rstn : present for interface uniformity; no state is held
//   bus       : master side of tinyqv_instr_decoder_if (instr in, decoded
//               immediate, class flags, alu/mem ops, register indices out)
// 32-bit words (instr[1:0]==11) are decoded here; anything else goes through
// tinyqv_rvc_expand and the two results are muxed on instr[1:0].
module tinyqv_instr_decoder
  import tinyqv_pkg::*;
(
  input logic                    clk,
  input logic                    rstn,
  tinyqv_instr_decoder_if.master bus
);

  logic [31:0] instr_s;
  logic [2:0]  funct3_s;
  logic        is_32_s;
  decode_t     d32_s;
  decode_t     d16_s;
  decode_t     dec_s;
  logic        unused_s;

  assign instr_s  = bus.instr;
  assign funct3_s = instr_s[14:12];
  assign is_32_s  = (instr_s[1:0] == 2'b11);
  assign unused_s = &{1'b0, clk, rstn};

  tinyqv_rvc_expand u_rvc (
    .cinstr (instr_s[15:0]),
    .dec    (d16_s)
  );

  // 32-bit opcode decode
  always_comb begin
    d32_s = decode_none();
    d32_s.rs1 = instr_s[18:15];
    d32_s.rs2 = instr_s[23:20];
    d32_s.rd  = instr_s[10:7];
    case (instr_s[6:2])
      OPC_LOAD: begin
        d32_s.is_load = 1'b1;
        d32_s.imm = {{20{instr_s[31]}}, instr_s[31:20]};
        d32_s.mem_op = funct3_s;
      end
      OPC_OP_IMM: begin
        d32_s.is_alu_imm = 1'b1;
        d32_s.imm = {{20{instr_s[31]}}, instr_s[31:20]};
        // Only SRLI/SRAI use instr[30] as an op bit; elsewhere it is immediate
        d32_s.alu_op = {(funct3_s == 3'b101) ? instr_s[30] : 1'b0, funct3_s};
      end
      OPC_AUIPC: begin
        d32_s.is_auipc = 1'b1;
        d32_s.imm = {instr_s[31:12], 12'd0};
      end
      OPC_STORE: begin
        d32_s.is_store = 1'b1;
        d32_s.imm = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
        d32_s.mem_op = funct3_s;
      end
      OPC_OP: begin
        d32_s.is_alu_reg = 1'b1;
        d32_s.alu_op = {instr_s[30], funct3_s};
      end
      OPC_LUI: begin
        d32_s.is_lui = 1'b1;
        d32_s.rs1 = 4'd0;
        d32_s.imm = {instr_s[31:12], 12'd0};
      end
      OPC_BRANCH: begin
        // mem_op carries funct3 so branch logic can invert the condition
        d32_s.is_branch = 1'b1;
        d32_s.imm = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25],
                     instr_s[11:8], 1'b0};
        d32_s.alu_op = branch_alu_op(funct3_s);
        d32_s.mem_op = funct3_s;
      end
      OPC_JALR: begin
        d32_s.is_jalr = 1'b1;
        d32_s.imm = {{20{instr_s[31]}}, instr_s[31:20]};
      end
      OPC_JAL: begin
        d32_s.is_jal = 1'b1;
        d32_s.imm = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20],
                     instr_s[30:21], 1'b0};
      end
      OPC_SYSTEM: begin
        d32_s.is_system = 1'b1;
        d32_s.imm = {20'd0, instr_s[31:20]};
      end
      default: d32_s = decode_none();
    endcase
  end

  assign dec_s = is_32_s ? d32_s : d16_s;

  assign bus.imm                  = dec_s.imm;
  assign bus.is_load              = dec_s.is_load;
  assign bus.is_alu_imm           = dec_s.is_alu_imm;
  assign bus.is_auipc             = dec_s.is_auipc;
  assign bus.is_store             = dec_s.is_store;
  assign bus.is_alu_reg           = dec_s.is_alu_reg;
  assign bus.is_lui               = dec_s.is_lui;
  assign bus.is_branch            = dec_s.is_branch;
  assign bus.is_jalr              = dec_s.is_jalr;
  assign bus.is_jal               = dec_s.is_jal;
  assign bus.is_system            = dec_s.is_system;
  assign bus.is_ret               = (instr_s == 32'h30200073);
  assign bus.instr_len            = is_32_s ? LEN_32 : LEN_16;
  assign bus.alu_op               = dec_s.alu_op;
  assign bus.mem_op               = dec_s.mem_op;
  assign bus.rs1                  = dec_s.rs1;
  assign bus.rs2                  = dec_s.rs2;
  assign bus.rd                   = dec_s.rd;
  assign bus.additional_mem_ops   = 3'b000;
  assign bus.mem_op_increment_reg = 1'b0;

endmodule

// File: tb/tb_tinyqv_instr_decoder.sv
// Directed bench for tinyqv_instr_decoder: hand-encoded RV32/RVC words with
// hand-computed expected fields.
module tb_tinyqv_instr_decoder;

  // Class flag order: {load, alu_imm, auipc, store, alu_reg, lui, branch, jalr, jal, system}
  localparam logic [9:0] C_NONE    = 10'b0000000000;
  localparam logic [9:0] C_LOAD    = 10'b1000000000;
  localparam logic [9:0] C_ALU_IMM = 10'b0100000000;
  localparam logic [9:0] C_AUIPC   = 10'b0010000000;
  localparam logic [9:0] C_STORE   = 10'b0001000000;
  localparam logic [9:0] C_ALU_REG = 10'b0000100000;
  localparam logic [9:0] C_LUI     = 10'b0000010000;
  localparam logic [9:0] C_BRANCH  = 10'b0000001000;
  localparam logic [9:0] C_JALR    = 10'b0000000100;
  localparam logic [9:0] C_JAL     = 10'b0000000010;
  localparam logic [9:0] C_SYSTEM  = 10'b0000000001;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  logic [9:0] cls;

  tinyqv_instr_decoder_if dif ();

  tinyqv_instr_decoder dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (dif)
  );

  assign cls = {dif.is_load, dif.is_alu_imm, dif.is_auipc, dif.is_store, dif.is_alu_reg,
                dif.is_lui, dif.is_branch, dif.is_jalr, dif.is_jal, dif.is_system};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a word after the rising edge, sample on the falling edge
  task automatic apply(input logic [31:0] i);
    @(posedge clk);
    dif.instr = i;
    @(negedge clk);
    check("additional_mem_ops", {29'd0, dif.additional_mem_ops}, 32'd0);
    check("mem_op_increment_reg", {31'd0, dif.mem_op_increment_reg}, 32'd0);
  endtask

  initial begin
    clk = 1'b0;
    rstn = 1'b0;
    checks = 0;
    errors = 0;
    dif.instr = 32'h00000000;

    // addi x1,x2,-1 while in reset: outputs must still follow instr
    apply(32'hFFF10093);
    check("rst addi cls", {22'd0, cls}, {22'd0, C_ALU_IMM});
    check("rst addi imm", dif.imm, 32'hFFFFFFFF);
    rstn = 1'b1;

    apply(32'hFFF10093);
    check("addi cls", {22'd0, cls}, {22'd0, C_ALU_IMM});
    check("addi imm", dif.imm, 32'hFFFFFFFF);
    check("addi rs1", {28'd0, dif.rs1}, 32'd2);
    check("addi rd", {28'd0, dif.rd}, 32'd1);
    check("addi alu_op", {28'd0, dif.alu_op}, 32'h0);
    check("addi len", {30'd0, dif.instr_len}, 32'd2);
    check("addi ret", {31'd0, dif.is_ret}, 32'd0);

    apply(32'h00512423);  // sw x5,8(x2)
    check("sw cls", {22'd0, cls}, {22'd0, C_STORE});
    check("sw imm", dif.imm, 32'd8);
    check("sw rs1", {28'd0, dif.rs1}, 32'd2);
    check("sw rs2", {28'd0, dif.rs2}, 32'd5);
    check("sw mem_op", {29'd0, dif.mem_op}, 32'd2);

    apply(32'h12345537);  // lui x10,0x12345
    check("lui cls", {22'd0, cls}, {22'd0, C_LUI});
    check("lui imm", dif.imm, 32'h12345000);
    check("lui rd", {28'd0, dif.rd}, 32'd10);
    check("lui rs1", {28'd0, dif.rs1}, 32'd0);

    apply(32'h402081B3);  // sub x3,x1,x2
    check("sub cls", {22'd0, cls}, {22'd0, C_ALU_REG});
    check("sub alu_op", {28'd0, dif.alu_op}, 32'h8);
    check("sub rd", {28'd0, dif.rd}, 32'd3);
    check("sub rs2", {28'd0, dif.rs2}, 32'd2);

    apply(32'hFE208EE3);  // beq x1,x2,-4
    check("beq cls", {22'd0, cls}, {22'd0, C_BRANCH});
    check("beq imm", dif.imm, 32'hFFFFFFFC);
    check("beq alu_op", {28'd0, dif.alu_op}, 32'h4);
    check("beq rs1", {28'd0, dif.rs1}, 32'd1);
    check("beq rs2", {28'd0, dif.rs2}, 32'd2);

    apply(32'h0020E463);  // bltu x1,x2,+8
    check("bltu imm", dif.imm, 32'd8);
    check("bltu alu_op", {28'd0, dif.alu_op}, 32'h3);

    apply(32'h40515513);  // srai x10,x2,5
    check("srai alu_op", {28'd0, dif.alu_op}, 32'hD);
    check("srai imm", dif.imm, 32'h00000405);

    apply(32'hFFE21183);  // lh x3,-2(x4)
    check("lh cls", {22'd0, cls}, {22'd0, C_LOAD});
    check("lh imm", dif.imm, 32'hFFFFFFFE);
    check("lh mem_op", {29'd0, dif.mem_op}, 32'd1);
    check("lh rs1", {28'd0, dif.rs1}, 32'd4);

    apply(32'h001000EF);  // jal x1,+2048
    check("jal cls", {22'd0, cls}, {22'd0, C_JAL});
    check("jal imm", dif.imm, 32'h00000800);

    apply(32'hFFFFF297);  // auipc x5,0xFFFFF
    check("auipc cls", {22'd0, cls}, {22'd0, C_AUIPC});
    check("auipc imm", dif.imm, 32'hFFFFF000);

    apply(32'h30200073);  // mret
    check("mret cls", {22'd0, cls}, {22'd0, C_SYSTEM});
    check("mret ret", {31'd0, dif.is_ret}, 32'd1);
    check("mret imm", dif.imm, 32'h00000302);

    apply(32'h0000007F);  // unknown opcode
    check("bad32 cls", {22'd0, cls}, {22'd0, C_NONE});
    check("bad32 len", {30'd0, dif.instr_len}, 32'd2);

    apply(32'h00004515);  // c.li x10,5
    check("c.li cls", {22'd0, cls}, {22'd0, C_ALU_IMM});
    check("c.li rs1", {28'd0, dif.rs1}, 32'd0);
    check("c.li rd", {28'd0, dif.rd}, 32'd10);
    check("c.li imm", dif.imm, 32'd5);
    check("c.li alu_op", {28'd0, dif.alu_op}, 32'h0);
    check("c.li len", {30'd0, dif.instr_len}, 32'd1);

    apply(32'h00004044);  // c.lw x9,4(x8)
    check("c.lw cls", {22'd0, cls}, {22'd0, C_LOAD});
    check("c.lw imm", dif.imm, 32'd4);
    check("c.lw rs1", {28'd0, dif.rs1}, 32'd8);
    check("c.lw rd", {28'd0, dif.rd}, 32'd9);
    check("c.lw mem_op", {29'd0, dif.mem_op}, 32'd2);

    apply(32'h0000BFFD);  // c.j -2
    check("c.j cls", {22'd0, cls}, {22'd0, C_JAL});
    check("c.j imm", dif.imm, 32'hFFFFFFFE);
    check("c.j rd", {28'd0, dif.rd}, 32'd0);

    apply(32'h00008C05);  // c.sub x8,x9
    check("c.sub cls", {22'd0, cls}, {22'd0, C_ALU_REG});
    check("c.sub alu_op", {28'd0, dif.alu_op}, 32'h8);
    check("c.sub rs1", {28'd0, dif.rs1}, 32'd8);
    check("c.sub rs2", {28'd0, dif.rs2}, 32'd9);

    apply(32'h00009282);  // c.jalr x5
    check("c.jalr cls", {22'd0, cls}, {22'd0, C_JALR});
    check("c.jalr rd", {28'd0, dif.rd}, 32'd1);
    check("c.jalr rs1", {28'd0, dif.rs1}, 32'd5);
    check("c.jalr imm", dif.imm, 32'd0);

    apply(32'h0000C61A);  // c.swsp x6,12(sp)
    check("c.swsp cls", {22'd0, cls}, {22'd0, C_STORE});
    check("c.swsp imm", dif.imm, 32'd12);
    check("c.swsp rs1", {28'd0, dif.rs1}, 32'd2);
    check("c.swsp rs2", {28'd0, dif.rs2}, 32'd6);
    check("c.swsp mem_op", {29'd0, dif.mem_op}, 32'd2);

    apply(32'h00000000);  // all-zero halfword is illegal
    check("bad16 cls", {22'd0, cls}, {22'd0, C_NONE});
    check("bad16 len", {30'd0, dif.instr_len}, 32'd1);

    // Reset mid-operation has no effect on the decode
    rstn = 1'b0;
    apply(32'h12345537);
    check("rst lui imm", dif.imm, 32'h12345000);
    rstn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
